// File: rtl/accum_lanes_if.sv
// Beat and result bundle between the MAC array and accum_lanes.
// The master drives the accumulation beats; the slave (accum_lanes) returns
// the rescaled per-lane results.
interface accum_lanes_if #(
    parameter int LANES  = 4,
    parameter int DWIDTH = 16
);
    logic                    clear;
    logic                    in_valid;
    logic                    last;
    logic [LANES*DWIDTH-1:0] bias_in;
    logic [LANES*DWIDTH-1:0] pixel_in;
    logic                    out_valid;
    logic [LANES*DWIDTH-1:0] pixel_out;
    logic [LANES-1:0]        sat_flag;
    logic                    busy;

    modport master (
        output clear, in_valid, last, bias_in, pixel_in,
        input  out_valid, pixel_out, sat_flag, busy
    );

    modport slave (
        input  clear, in_valid, last, bias_in, pixel_in,
        output out_valid, pixel_out, sat_flag, busy
    );
endinterface

// File: rtl/accum_lanes.sv
// Multi-lane saturating accumulator. Each lane sums a bias plus a stream of
// signed terms in a wide register; the beat flagged last emits a floor-shifted,
// saturated narrow result per lane together with a sticky clip flag.
module accum_lanes #(
    parameter int LANES  = 4,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 24,
    parameter int FRAC   = 8
) (
    input  logic          clk,
    input  logic          xrst,
    accum_lanes_if.slave  bus
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic signed [AWIDTH-1:0] ACC_MAX = {1'b0, {(AWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] ACC_MIN = {1'b1, {(AWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0]        OUT_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0]        OUT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    state_t                        state_q, state_d;
    logic [LANES-1:0][AWIDTH-1:0]  acc_q, acc_d;
    logic [LANES-1:0]              sticky_q, sticky_d;
    logic                          out_valid_q, out_valid_d;
    logic [LANES*DWIDTH-1:0]       pixel_out_q, pixel_out_d;
    logic [LANES-1:0]              sat_flag_q, sat_flag_d;

    logic start_beat;
    logic cont_beat;
    logic accept;

    function automatic logic [AWIDTH-1:0] sext(input logic [DWIDTH-1:0] v);
        return {{(AWIDTH-DWIDTH){v[DWIDTH-1]}}, v};
    endfunction

    // A clear with a valid beat restarts the sum from this beat's bias.
    assign start_beat = bus.in_valid & ((state_q == IDLE) | bus.clear);
    assign cont_beat  = bus.in_valid & ~bus.clear & (state_q == ACC);
    assign accept     = start_beat | cont_beat;

    // Next-state, per-lane saturating add, rescale and output saturation.
    always_comb begin
        logic [AWIDTH-1:0]        base;
        logic [AWIDTH:0]          wide;
        logic signed [AWIDTH-1:0] nxt;
        logic signed [AWIDTH-1:0] shf;
        logic [AWIDTH-DWIDTH:0]   upper;
        logic                     clip;
        logic                     oclip;
        logic                     sticky_base;

        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value unassigned and infers a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = 1'b0;
        pixel_out_d = pixel_out_q;
        sat_flag_d  = sat_flag_q;
        base        = '0;
        wide        = '0;
        nxt         = '0;
        shf         = '0;
        upper       = '0;
        clip        = 1'b0;
        oclip       = 1'b0;
        sticky_base = 1'b0;

        if (accept) begin
            state_d = bus.last ? IDLE : ACC;
        end else if (bus.clear) begin
            state_d = IDLE;
        end

        for (int l = 0; l < LANES; l++) begin
            base = start_beat ? sext(bus.bias_in[l*DWIDTH +: DWIDTH]) : acc_q[l];
            // One guard bit exposes overflow of the signed add.
            wide = {base[AWIDTH-1], base}
                 + {bus.pixel_in[l*DWIDTH + DWIDTH-1], sext(bus.pixel_in[l*DWIDTH +: DWIDTH])};
            clip = (wide[AWIDTH] != wide[AWIDTH-1]);
            if (clip) begin
                nxt = wide[AWIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                nxt = wide[AWIDTH-1:0];
            end

            shf   = nxt >>> FRAC;
            upper = shf[AWIDTH-1:DWIDTH-1];
            oclip = ~((&upper) | ~(|upper));

            sticky_base = start_beat ? 1'b0 : sticky_q[l];

            if (accept) begin
                acc_d[l]    = nxt;
                sticky_d[l] = bus.last ? 1'b0 : (sticky_base | clip);
                if (bus.last) begin
                    sat_flag_d[l] = sticky_base | clip | oclip;
                    if (oclip) begin
                        pixel_out_d[l*DWIDTH +: DWIDTH] = shf[AWIDTH-1] ? OUT_MIN : OUT_MAX;
                    end else begin
                        pixel_out_d[l*DWIDTH +: DWIDTH] = shf[DWIDTH-1:0];
                    end
                end
            end
        end

        out_valid_d = accept & bus.last;
    end

    // State, accumulators and registered outputs.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sticky_q    <= '0;
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
            sat_flag_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values
            // computed above, independent of statement order.
            state_q     <= state_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            pixel_out_q <= pixel_out_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.pixel_out = pixel_out_q;
    assign bus.sat_flag  = sat_flag_q;
    assign bus.busy      = (state_q == ACC);

endmodule

// File: tb/tb_accum_lanes.sv
// Bench for accum_lanes: two instances (FRAC=0 and FRAC=8) share one stimulus
// stream. A behavioural model predicts each result and queues it; a monitor
// pops and compares whenever an instance raises out_valid.
module tb_accum_lanes;

    localparam int L  = 4;
    localparam int DW = 16;

    typedef struct {
        logic [L*DW-1:0] pix;
        logic [L-1:0]    sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            xrst = 1'b0;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            last = 1'b0;
    logic [L*DW-1:0] bias_in = '0;
    logic [L*DW-1:0] pixel_in = '0;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // Model state: plain integer sums per lane.
    bit     m_busy = 0;
    longint m_acc[L];
    bit     m_sticky[L];

    localparam longint AMAX = 64'sd8388607;
    localparam longint AMIN = -64'sd8388608;

    accum_lanes_if #(.LANES(L), .DWIDTH(DW)) bus0();
    accum_lanes_if #(.LANES(L), .DWIDTH(DW)) bus1();

    assign bus0.clear = clear;    assign bus1.clear = clear;
    assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid;
    assign bus0.last = last;      assign bus1.last = last;
    assign bus0.bias_in = bias_in;  assign bus1.bias_in = bias_in;
    assign bus0.pixel_in = pixel_in; assign bus1.pixel_in = pixel_in;

    accum_lanes #(.LANES(L), .DWIDTH(DW), .AWIDTH(24), .FRAC(0)) dut0 (
        .clk(clk), .xrst(xrst), .bus(bus0.slave)
    );
    accum_lanes #(.LANES(L), .DWIDTH(DW), .AWIDTH(24), .FRAC(8)) dut1 (
        .clk(clk), .xrst(xrst), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [L*DW-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Apply the spec's rules to one beat and queue any result it produces.
    task automatic model_step(input bit v, input bit lst, input bit clr,
                              input logic [L*DW-1:0] bias, input logic [L*DW-1:0] pix);
        bit start;
        exp_t x0, x1;
        logic signed [15:0] t;
        longint s, o, b, p;
        bit flag, of;
        if (!v) begin
            if (clr) m_busy = 0;
            return;
        end
        start = !m_busy || clr;
        for (int l = 0; l < L; l++) begin
            t = bias[l*DW +: DW]; b = t;
            t = pix[l*DW +: DW];  p = t;
            s = (start ? b : m_acc[l]) + p;
            flag = start ? 1'b0 : m_sticky[l];
            if (s > AMAX) begin s = AMAX; flag = 1; end
            else if (s < AMIN) begin s = AMIN; flag = 1; end
            m_acc[l] = s;
            m_sticky[l] = flag;
            for (int f = 0; f < 2; f++) begin
                o = s >>> (f * 8);
                of = flag;
                if (o > 32767) begin o = 32767; of = 1; end
                else if (o < -32768) begin o = -32768; of = 1; end
                if (f == 0) begin x0.pix[l*DW +: DW] = o[15:0]; x0.sat[l] = of; end
                else        begin x1.pix[l*DW +: DW] = o[15:0]; x1.sat[l] = of; end
            end
        end
        if (lst) begin
            q0.push_back(x0);
            q1.push_back(x1);
        end
        m_busy = !lst;
    endtask

    // Drive one cycle of inputs, let the DUTs take the edge, then check busy.
    task automatic beat(input bit v, input bit lst, input bit clr,
                        input logic [L*DW-1:0] bias, input logic [L*DW-1:0] pix);
        in_valid = v; last = lst; clear = clr; bias_in = bias; pixel_in = pix;
        model_step(v, lst, clr, bias, pix);
        @(posedge clk); #1;
        check("dut0_busy", 64'(bus0.busy), 64'(m_busy));
        check("dut1_busy", 64'(bus1.busy), 64'(m_busy));
        in_valid = 0; last = 0; clear = 0;
    endtask

    // Directed check of lane 0 right after the last beat's edge.
    task automatic lane0(input string name, input int exp0, input int exp1);
        logic [15:0] x0, x1;
        x0 = exp0[15:0]; x1 = exp1[15:0];
        check({name, "_out_valid"}, 64'(bus0.out_valid & bus1.out_valid), 64'd1);
        check({name, "_dut0_lane0"}, 64'(bus0.pixel_out[15:0]), 64'(x0));
        check({name, "_dut1_lane0"}, 64'(bus1.pixel_out[15:0]), 64'(x1));
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (xrst && bus0.out_valid) begin
            if (q0.size() == 0) check("dut0_unexpected_out_valid", 64'd1, 64'd0);
            else begin
                e0 = q0.pop_front();
                check("dut0_pixel_out", 64'(bus0.pixel_out), 64'(e0.pix));
                check("dut0_sat_flag", 64'(bus0.sat_flag), 64'(e0.sat));
            end
        end
        if (xrst && bus1.out_valid) begin
            if (q1.size() == 0) check("dut1_unexpected_out_valid", 64'd1, 64'd0);
            else begin
                e1 = q1.pop_front();
                check("dut1_pixel_out", 64'(bus1.pixel_out), 64'(e1.pix));
                check("dut1_sat_flag", 64'(bus1.sat_flag), 64'(e1.sat));
            end
        end
    end

    initial begin
        logic [L*DW-1:0] bv, pv;
        int sel;

        // Reset state.
        #12;
        check("rst_out_valid", 64'(bus0.out_valid | bus1.out_valid), 64'd0);
        check("rst_busy", 64'(bus0.busy | bus1.busy), 64'd0);
        xrst = 1;
        @(posedge clk); #1;

        // Single-beat sum: 170 + 5.
        beat(1, 1, 0, pk(170, -3, 0, 1000), pk(5, -4, 0, -1));
        lane0("single_beat", 175, 0);

        // Reset mid-sum.
        beat(1, 0, 0, pk(1, 2, 3, 4), pk(10, 20, 30, 40));
        beat(1, 0, 0, 0, pk(10, 20, 30, 40));
        #2 xrst = 0;
        #1;
        check("rst_mid_out_valid", 64'(bus0.out_valid | bus1.out_valid), 64'd0);
        check("rst_mid_busy", 64'(bus0.busy | bus1.busy), 64'd0);
        check("rst_mid_pixel_out", 64'(bus0.pixel_out | bus1.pixel_out), 64'd0);
        check("rst_mid_sat_flag", 64'(bus0.sat_flag | bus1.sat_flag), 64'd0);
        m_busy = 0;
        #3 xrst = 1;
        @(posedge clk); #1;

        // Gap in the middle of a sum: 0 + 5 + 5 + 7.
        beat(1, 0, 0, pk(0, 100, -50, 7), pk(5, -7, 100, -1000));
        beat(0, 1, 0, pk(9, 9, 9, 9), pk(999, 999, 999, 999));
        beat(1, 0, 0, pk(9, 9, 9, 9), pk(5, 3, -2, 500));
        beat(1, 1, 0, 0, pk(7, 1, 1, 1));
        lane0("gap_sum", 17, 0);

        // Output saturation, then a clean sum that must not carry the flag.
        beat(1, 0, 0, 0, pk(32767, 32767, -32768, 1));
        beat(1, 0, 0, 0, pk(32767, 32767, -32768, 1));
        beat(1, 1, 0, 0, pk(32767, 32767, 0, 1));
        lane0("pos_out_sat", 32767, 383);
        check("pos_out_sat_flag", 64'(bus0.sat_flag[0]), 64'd1);
        beat(1, 0, 0, 0, pk(-32768, 0, 0, 0));
        beat(1, 1, 0, 0, pk(-32768, 0, 0, 0));
        lane0("neg_out_sat", -32768, -256);
        check("neg_out_sat_flag", 64'(bus0.sat_flag[0]), 64'd1);
        beat(1, 1, 0, pk(2, 2, 2, 2), pk(3, 3, 3, 3));
        check("sat_flag_cleared", 64'(bus0.sat_flag | bus1.sat_flag), 64'd0);

        // Accumulator saturation at both bounds, held by the sticky flag.
        beat(1, 0, 0, pk(32767, -32768, 32767, -32768), pk(32767, -32768, 32767, -32768));
        for (int i = 0; i < 300; i++)
            beat(1, 0, 0, 0, pk(32767, -32768, 32767, -32768));
        beat(1, 1, 0, 0, pk(-1, 1, 0, 0));
        lane0("acc_sat", 32767, 32767);
        check("acc_sat_flag_dut1", 64'(bus1.sat_flag), 64'hF);

        // Clear without a valid beat discards the sum.
        beat(1, 0, 0, 0, pk(10, 10, 10, 10));
        beat(1, 0, 0, 0, pk(10, 10, 10, 10));
        beat(0, 0, 1, 0, 0);
        check("clear_no_out_valid", 64'(bus0.out_valid | bus1.out_valid), 64'd0);
        beat(0, 0, 0, 0, 0);
        check("clear_still_no_out", 64'(bus0.out_valid | bus1.out_valid), 64'd0);

        // Clear with a valid beat restarts from this beat's bias.
        beat(1, 0, 0, pk(50, 50, 50, 50), pk(10, 10, 10, 10));
        beat(1, 0, 1, pk(1, -1, 2, -2), pk(3, 3, 3, 3));
        beat(1, 1, 0, pk(77, 77, 77, 77), 0);
        lane0("clear_restart", 4, 0);

        // Floor rescale with FRAC=8.
        beat(1, 0, 0, 0, pk(200, 0, 0, 0));
        beat(1, 1, 0, 0, pk(184, 0, 0, 0));
        lane0("frac_pos", 384, 1);
        beat(1, 0, 0, 0, pk(-200, 0, 0, 0));
        beat(1, 1, 0, 0, pk(-184, 0, 0, 0));
        lane0("frac_neg", -384, -2);

        // Randomized stream, including back-to-back starts after last.
        for (int i = 0; i < 600; i++) begin
            for (int l = 0; l < L; l++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: pv[l*DW +: DW] = 16'h7FFF;
                    1: pv[l*DW +: DW] = 16'h8000;
                    2: pv[l*DW +: DW] = 16'($urandom_range(0, 40));
                    default: pv[l*DW +: DW] = 16'($urandom);
                endcase
                bv[l*DW +: DW] = 16'($urandom);
            end
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0, bv, pv);
        end

        // Drain and confirm every predicted result appeared.
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("dut0_queue_drained", 64'(q0.size()), 64'd0);
        check("dut1_queue_drained", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
